// File: rtl/bram_pkg.sv
// Shared types and width helpers for the BRAM burst read path.
// Module-level widths come from the helper functions applied to each instance's parameters.
package bram_pkg;

   typedef enum logic {IDLE, BURST} bram_rd_state_e;

   function automatic int calc_addr_width(input int ram_depth);
      return $clog2(ram_depth);
   endfunction

   function automatic int calc_beat_width(input int beats);
      return $clog2(beats);
   endfunction

   function automatic int calc_req_width(input int ram_depth, input int beats);
      return $clog2(ram_depth) - $clog2(beats);
   endfunction

   // Widths for the default configuration (512 words, 2 beats per line).
   localparam int DEFAULT_RAM_DEPTH = 512;
   localparam int DEFAULT_BEATS     = 2;
   localparam int ADDR_WIDTH        = calc_addr_width(DEFAULT_RAM_DEPTH);
   localparam int BEAT_WIDTH        = calc_beat_width(DEFAULT_BEATS);
   localparam int REQ_WIDTH         = calc_req_width(DEFAULT_RAM_DEPTH, DEFAULT_BEATS);

endpackage

// File: rtl/bram_rd_fifo.sv
// First-word-fall-through FIFO holding packed lines until the consumer takes them.
// Depth need not be a power of two; pointers wrap explicitly.
module bram_rd_fifo #(
   parameter int DEPTH = 6,
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_WIDTH = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_WIDTH-1:0] count_reg;
   logic                 do_push, do_pop;

   function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
   endfunction

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_WIDTH'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
         if (do_push && !do_pop)      count_reg <= count_reg + CNT_WIDTH'(1);
         else if (do_pop && !do_push) count_reg <= count_reg - CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/bram_burst_reader.sv
// Reads BEATS consecutive BRAM words per line request and packs them into one output word.
// Credits track free FIFO slots so the read pipeline itself never has to stall.
module bram_burst_reader #(
   parameter int  DATA_WIDTH   = 64,
   parameter int  RAM_DEPTH    = 512,
   parameter int  BEATS        = 2,
   parameter int  READ_LATENCY = 2,
   parameter int  CREDITS      = 6,
   localparam int ADDR_WIDTH   = bram_pkg::calc_addr_width(RAM_DEPTH),
   localparam int BEAT_WIDTH   = bram_pkg::calc_beat_width(BEATS),
   localparam int REQ_WIDTH    = bram_pkg::calc_req_width(RAM_DEPTH, BEATS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_v,
   output logic                        i_r,
   input  logic [REQ_WIDTH-1:0]        i_d,
   output logic                        o_v,
   input  logic                        o_r,
   output logic [BEATS*DATA_WIDTH-1:0] o_d,
   input  logic                        i_we,
   input  logic [ADDR_WIDTH-1:0]       i_wa,
   input  logic [DATA_WIDTH-1:0]       i_wd
);

   localparam int CRED_WIDTH = $clog2(CREDITS + 1);
   localparam int LINE_WIDTH = BEATS * DATA_WIDTH;
   localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

   bram_pkg::bram_rd_state_e state_reg, state_next;
   logic [BEAT_WIDTH-1:0] beat_reg, beat_next;
   logic [REQ_WIDTH-1:0]  addr_reg, addr_next;
   logic [CRED_WIDTH-1:0] credits_reg;
   logic                  accept, pop, push, fifo_empty, fifo_full, rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;

   assign accept  = i_v && i_r;
   assign pop     = o_v && o_r;
   assign i_r     = !reset && credits_reg != '0 &&
                    (state_reg == bram_pkg::IDLE || beat_reg == LAST_BEAT);
   assign rd_en   = (state_reg == bram_pkg::BURST);
   assign rd_addr = {addr_reg, beat_reg};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= bram_pkg::IDLE;
         beat_reg  <= '0;
         addr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
         addr_reg  <= addr_next;
      end
   end

   // A new request taken on the last beat restarts the burst with no idle cycle.
   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      addr_next  = addr_reg;
      case (state_reg)
         bram_pkg::IDLE: begin
            if (accept) begin
               state_next = bram_pkg::BURST;
               beat_next  = '0;
               addr_next  = i_d;
            end
         end
         bram_pkg::BURST: begin
            if (beat_reg == LAST_BEAT) begin
               beat_next = '0;
               if (accept) addr_next  = i_d;
               else        state_next = bram_pkg::IDLE;
            end else begin
               beat_next = beat_reg + BEAT_WIDTH'(1);
            end
         end
         default: state_next = bram_pkg::IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                credits_reg <= CRED_WIDTH'(CREDITS);
      else if (accept && !pop)  credits_reg <= credits_reg - CRED_WIDTH'(1);
      else if (pop && !accept)  credits_reg <= credits_reg + CRED_WIDTH'(1);
   end

   // Read-first: the read samples the array before this edge's write lands.
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] ram_q;
   logic                  v1_reg;
   logic [BEAT_WIDTH-1:0] b1_reg;

   always_ff @(posedge clk) begin
      if (i_we)  mem[i_wa] <= i_wd;
      if (rd_en) ram_q <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_reg <= 1'b0;
         b1_reg <= '0;
      end else begin
         v1_reg <= rd_en;
         b1_reg <= beat_reg;
      end
   end

   logic                  lane_v;
   logic [BEAT_WIDTH-1:0] lane_beat;
   logic [DATA_WIDTH-1:0] lane_data;

   generate
      if (READ_LATENCY == 2) begin : g_out_reg
         logic                  v2_reg;
         logic [BEAT_WIDTH-1:0] b2_reg;
         logic [DATA_WIDTH-1:0] q2_reg;
         always_ff @(posedge clk) begin
            q2_reg <= ram_q;
            if (reset) begin
               v2_reg <= 1'b0;
               b2_reg <= '0;
            end else begin
               v2_reg <= v1_reg;
               b2_reg <= b1_reg;
            end
         end
         assign lane_v    = v2_reg;
         assign lane_beat = b2_reg;
         assign lane_data = q2_reg;
      end else begin : g_no_out_reg
         assign lane_v    = v1_reg;
         assign lane_beat = b1_reg;
         assign lane_data = ram_q;
      end
   endgenerate

   // The last beat is not stored; it feeds the FIFO directly as it lands.
   logic [LINE_WIDTH-1:0] line_word;

   for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
      if (gi == BEATS - 1) begin : g_last
         assign line_word[gi*DATA_WIDTH +: DATA_WIDTH] = lane_data;
      end else begin : g_held
         logic [DATA_WIDTH-1:0] lane_reg;
         always_ff @(posedge clk) begin
            if (lane_v && lane_beat == BEAT_WIDTH'(gi)) lane_reg <= lane_data;
         end
         assign line_word[gi*DATA_WIDTH +: DATA_WIDTH] = lane_reg;
      end
   end

   assign push = lane_v && (lane_beat == LAST_BEAT);

   bram_rd_fifo #(
      .DEPTH (CREDITS),
      .WIDTH (LINE_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (line_word),
      .pop   (pop),
      .dout  (o_d),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign o_v = !fifo_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (credits_reg <= CRED_WIDTH'(CREDITS));
         assert (!(pop && !accept && credits_reg == CRED_WIDTH'(CREDITS)));
         assert (!(accept && !pop && credits_reg == '0));
         assert (!(push && fifo_full));
      end
   end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Scoreboard bench: stimulus queues hand-computed lines, a monitor compares every pop.
// A second instance covers the 4-beat, unregistered-output configuration.
module tb_bram_burst_reader;

   logic         clk = 1'b0;
   logic         reset;
   logic         i_v, i_r, o_v, o_r, i_we;
   logic [bram_pkg::REQ_WIDTH-1:0]  i_d;
   logic [bram_pkg::ADDR_WIDTH-1:0] i_wa;
   logic [63:0]  i_wd;
   logic [127:0] o_d;

   logic         b_i_v, b_i_r, b_o_v, b_o_r, b_we;
   logic [3:0]   b_i_d;
   logic [5:0]   b_wa;
   logic [15:0]  b_wd;
   logic [63:0]  b_o_d;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rise_cyc = 0;
   int last_acc = 0;
   logic o_v_prev = 1'b0;
   logic [127:0] exp_q[$];
   int pop_cyc_q[$];
   int acc_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bram_burst_reader u_dut (
      .clk (clk), .reset (reset), .i_v (i_v), .i_r (i_r), .i_d (i_d),
      .o_v (o_v), .o_r (o_r), .o_d (o_d),
      .i_we (i_we), .i_wa (i_wa), .i_wd (i_wd)
   );

   bram_burst_reader #(
      .DATA_WIDTH (16), .RAM_DEPTH (64), .BEATS (4), .READ_LATENCY (1), .CREDITS (2)
   ) u_dut4 (
      .clk (clk), .reset (reset), .i_v (b_i_v), .i_r (b_i_r), .i_d (b_i_d),
      .o_v (b_o_v), .o_r (b_o_r), .o_d (b_o_d),
      .i_we (b_we), .i_wa (b_wa), .i_wd (b_wd)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, want);
      end
   endtask

   // Monitor: every pop is compared against the oldest queued expectation.
   always @(negedge clk) begin
      if (o_v === 1'b1 && o_r === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got %h expected none", o_d);
         end else begin
            chk("line_data", o_d, exp_q.pop_front());
            pop_cyc_q.push_back(cyc);
         end
      end
      if (o_v === 1'b1 && o_v_prev !== 1'b1) rise_cyc = cyc;
      o_v_prev = o_v;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [8:0] a, input logic [63:0] d);
      i_we = 1'b1; i_wa = a; i_wd = d;
      step();
      i_we = 1'b0;
   endtask

   task automatic send(input logic [7:0] a, input logic [63:0] hi, input logic [63:0] lo);
      int n = 0;
      i_v = 1'b1;
      i_d = a;
      forever begin
         @(negedge clk);
         if (i_r) break;
         n++;
         if (n > 200) break;
      end
      if (n > 200) begin
         chk("accept_timeout", 0, 1);
      end else begin
         exp_q.push_back({hi, lo});
         last_acc = cyc;
         acc_q.push_back(cyc);
      end
      step();
      i_v = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      step();
   endtask

   initial begin
      reset = 1'b1; i_v = 1'b0; i_d = '0; o_r = 1'b1; i_we = 1'b0; i_wa = '0; i_wd = '0;
      b_i_v = 1'b0; b_i_d = '0; b_o_r = 1'b1; b_we = 1'b0; b_wa = '0; b_wd = '0;
      repeat (3) step();
      chk("reset_i_r", i_r, 0);
      chk("reset_o_v", o_v, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_i_r", i_r, 1);
      step();

      for (int k = 0; k < 16; k++) wr(9'(k), 64'(k));
      wr(9'd510, 64'h1FE);
      wr(9'd511, 64'h1FF);
      for (int k = 60; k < 64; k++) begin
         b_we = 1'b1; b_wa = 6'(k); b_wd = 16'(k);
         step();
      end
      b_we = 1'b0;

      // Single request, latency and packing order.
      send(8'd1, 64'h3, 64'h2);
      wait_drain();
      chk("latency_default", rise_cyc - last_acc, 5);

      // Back-to-back requests: one accept and one output every second cycle.
      pop_cyc_q.delete();
      acc_q.delete();
      send(8'd0, 64'h1, 64'h0);
      send(8'd1, 64'h3, 64'h2);
      send(8'd2, 64'h5, 64'h4);
      send(8'd3, 64'h7, 64'h6);
      wait_drain();
      chk("thr_accepts", acc_q.size(), 4);
      chk("thr_pops", pop_cyc_q.size(), 4);
      if (acc_q.size() == 4 && pop_cyc_q.size() == 4) begin
         for (int k = 1; k < 4; k++) begin
            chk($sformatf("thr_acc_gap%0d", k), acc_q[k] - acc_q[k-1], 2);
            chk($sformatf("thr_pop_gap%0d", k), pop_cyc_q[k] - pop_cyc_q[k-1], 2);
         end
      end

      // Backpressure: six credits, then blocked until one pop.
      o_r = 1'b0;
      send(8'd0, 64'h1, 64'h0);
      send(8'd1, 64'h3, 64'h2);
      send(8'd2, 64'h5, 64'h4);
      send(8'd3, 64'h7, 64'h6);
      send(8'd4, 64'h9, 64'h8);
      send(8'd5, 64'hB, 64'hA);
      i_v = 1'b1;
      i_d = 8'd6;
      repeat (20) @(negedge clk);
      chk("credit_block", i_r, 0);
      chk("hold_head", o_d, {64'h1, 64'h0});
      step();
      o_r = 1'b1;
      step();
      o_r = 1'b0;
      @(negedge clk);
      chk("credit_return", i_r, 1);
      exp_q.push_back({64'hD, 64'hC});
      step();
      i_v = 1'b0;
      o_r = 1'b1;
      wait_drain();

      // Write to word 4 in the same cycle beat 0 reads it: old data comes back.
      send(8'd2, 64'h5, 64'h4);
      wr(9'd4, 64'hAA);
      wait_drain();
      send(8'd2, 64'h5, 64'hAA);
      wait_drain();

      // Reset with three requests in flight discards everything.
      o_r = 1'b0;
      i_v = 1'b1;
      i_d = 8'd3;
      repeat (5) step();
      i_v = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_i_r_low", i_r, 0);
      step();
      @(negedge clk);
      chk("rst_o_v_clear", o_v, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_release_i_r", i_r, 1);
      o_r = 1'b1;
      repeat (20) @(negedge clk);
      chk("no_stale_o_v", o_v, 0);
      step();
      send(8'd1, 64'h3, 64'h2);
      wait_drain();

      // Top line of the array.
      send(8'd255, 64'h1FF, 64'h1FE);
      wait_drain();

      // Four-beat instance, unregistered BRAM output, top line.
      begin
         int t_acc = 0;
         int t_v = 0;
         int n = 0;
         b_i_v = 1'b1;
         b_i_d = 4'hF;
         forever begin
            @(negedge clk);
            if (b_i_r) break;
            n++;
            if (n > 50) break;
         end
         t_acc = cyc;
         step();
         b_i_v = 1'b0;
         n = 0;
         forever begin
            @(negedge clk);
            if (b_o_v) break;
            n++;
            if (n > 50) break;
         end
         t_v = cyc;
         chk("b_o_v_seen", b_o_v, 1);
         chk("b_latency", t_v - t_acc, 6);
         chk("b_line_data", b_o_d, {16'h003F, 16'h003E, 16'h003D, 16'h003C});
      end

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_burst_reader.md
# bram_burst_reader

Single-clock, parametrised successor to the double-pumped L1 BRAM read path. Accepts one read request per cache-line slice and issues BEATS consecutive single-port BRAM reads. The beats are packed into one BEATS*DATA_WIDTH output word. A credit counter sized to an internal output FIFO gives full backpressure without stalling the BRAM pipeline. It sits between the stream request arbiter and the per-stream output buffers, owns the BRAM array, and exposes the write port to the line-fill logic.

## Interface
- DATA_WIDTH, 64, bits per BRAM word (one beat)
- RAM_DEPTH, 512, BRAM words; power of two
- BEATS, 2, reads per request; power of two, 2..16
- READ_LATENCY, 2, BRAM read latency in cycles; 1 (unregistered output) or 2 (output register)
- CREDITS, 6, outstanding requests allowed; equals output FIFO depth; 1..32
- Derived: ADDR_WIDTH=$clog2(RAM_DEPTH), BEAT_WIDTH=$clog2(BEATS), REQ_WIDTH=ADDR_WIDTH-BEAT_WIDTH
- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high
- i_v  in  1  request valid
- i_r  out  1  request ready
- i_d  in  REQ_WIDTH  request base address (line index)
- o_v  out  1  packed data valid
- o_r  in  1  packed data ready
- o_d  out  BEATS*DATA_WIDTH  packed line data
- i_we  in  1  write enable
- i_wa  in  ADDR_WIDTH  write address
- i_wd  in  DATA_WIDTH  write data

## Operation
- Credit counter: reset value CREDITS.
  - Decrements on request accept (i_v&i_r).
  - Increments on output pop (o_v&o_r).
  - Both in one cycle: unchanged.
  - Never exceeds CREDITS and never goes below 0; an assertion checks both.
- FSM states IDLE and BURST; reset state IDLE.
  - i_r = (state==IDLE || beat==BEATS-1) && credits!=0.
  - IDLE: on accept, latch i_d and go to BURST with beat counter=0.
  - BURST: each cycle, issue a read at {addr_q, beat}, then increment beat.
  - On the beat==BEATS-1 cycle: go to BURST with beat=0 if a new request is accepted that cycle, otherwise go to IDLE.
  - Sustained throughput is one request per BEATS cycles with no bubble.
- Read pipeline: the read-enable valid bit and beat index are delayed READ_LATENCY cycles alongside the BRAM data.
- Pack: beat k lands in o_d[k*DATA_WIDTH +: DATA_WIDTH], so beat 0 is the least significant.
- Push: when the last beat lands, the completed word is pushed into the FIFO on the next edge.
- Read-during-write to the same address returns the old data (read-first). Writes never stall.
- FIFO is first-word-fall-through: o_v = !empty and o_d = head. Credits guarantee it never overflows, so push-when-full is an assertion failure.
- o_d is stable while o_v && !o_r.

## Timing
- Request accepted at cycle T:
  - beat k is read at T+1+k;
  - beat k data is valid at T+1+k+READ_LATENCY;
  - o_v rises at T+BEATS+READ_LATENCY+1.
  - With defaults (BEATS=2, READ_LATENCY=2), o_v rises at T+5.
- Reset values: i_r=0 during reset and 1 on the first cycle after; o_v=0; credits=CREDITS; FSM in IDLE; beat=0; FIFO empty; pipeline valids 0.
- Reset mid-burst: all in-flight beats and FIFO contents are discarded. BRAM contents are not cleared.
- Credits=0: i_r=0 even in IDLE. The next credit is usable in the cycle after the pop.
- Address wrap: i_d=2^REQ_WIDTH-1 reads the top BEATS words. There is no carry into other lines.

## Structure
- Package bram_pkg holds:
  - typedef enum logic {IDLE, BURST} bram_rd_state_e;
  - localparams for ADDR_WIDTH, BEAT_WIDTH and REQ_WIDTH as functions of the parameters.
- The BRAM array is inferred inline: one write port and one read port, with an optional output register selected by READ_LATENCY.
- One sub-module: bram_rd_fifo, a synchronous FWFT FIFO with parameters DEPTH and WIDTH and ports clk, reset, push, din, pop, dout, empty, full.

## Test plan
- Load words 0..7 with 0x00..07, then request i_d=1 with o_r=1 (defaults) -> o_v at T+5, o_d={0x03,0x02}.
- Hold i_v=1 with i_d=0,1,2,3 and o_r=1 -> i_r high every 2nd cycle, four outputs on consecutive even cycles in request order.
- Hold o_r=0 and issue requests -> exactly 6 accepted, then i_r=0. One pop makes i_r=1 on the next cycle, and the data order is preserved.
- Write 0xAA to word 4 in the same cycle that beat 0 of i_d=2 reads word 4 -> o_d[63:0] returns the old value. A repeat read returns 0xAA.
- Assert reset during BURST with 3 requests in flight -> o_v=0 next cycle, i_r=1 after reset deasserts, and no stale words appear.
- BEATS=4, READ_LATENCY=1, i_d=REQ max -> o_v at T+6 with words RAM_DEPTH-4..RAM_DEPTH-1 packed low to high.
